uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer sitting directly downstream of the UART receiver. It captures each completed character with its frame and parity error flags, acknowledges the receiver with a `clear_rx_ready` pulse, and queues entries in a first-word-fall-through FIFO for the CPU-side register interface. It detects overrun when the FIFO is full, and provides a flush control and a threshold interrupt.

## Interface
Parameters:
- DEPTH, 16: FIFO entries. Must be a power of 2, ≥ 2.
- THRESHOLD, 8: `rx_irq` asserts when `count` ≥ THRESHOLD. Range 1..DEPTH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_ready  in  1  from receiver: character held and valid
- rx_data  in  8  from receiver: character
- frame_error  in  1  from receiver
- parity_error  in  1  from receiver
- clear_rx_ready  out  1  to receiver: one-cycle acknowledge pulse, registered
- rd_en  in  1  pop head entry; ignored when empty
- rd_data  out  8  head character; valid when !empty
- rd_frame_error  out  1  head entry frame flag
- rd_parity_error  out  1  head entry parity flag
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  $clog2(DEPTH)+1  entries stored, 0..DEPTH
- overrun  out  1  sticky: a character was dropped
- clear_overrun  in  1  clears `overrun`
- flush  in  1  synchronous flush of FIFO contents
- rx_irq  out  1  level: count ≥ THRESHOLD

## Operation
Capture FSM has three states: CAP_IDLE, CAP_ACK, CAP_WAIT_LOW.
- CAP_IDLE:
  - If `rx_ready` = 1, latch {`parity_error`, `frame_error`, `rx_data`}.
  - If the push is accepted, write the entry. Otherwise drop it and set `overrun`.
  - Set `clear_rx_ready` <= 1 and go to CAP_ACK.
- CAP_ACK: `clear_rx_ready` <= 0, go to CAP_WAIT_LOW.
- CAP_WAIT_LOW: stay until `rx_ready` = 0, then go to CAP_IDLE. This guarantees exactly one capture per character.

The receiver only acts on `clear_rx_ready` in its IDLE state. It is always in IDLE by the time `rx_ready` is visible here, so one pulse is sufficient.

Push acceptance: accepted when !`full` || (`rd_en` && !`empty`). A simultaneous pop while full frees the slot in the same cycle, so no overrun occurs.

FIFO storage and pointers:
- Storage is a register array with wr_ptr and rd_ptr of $clog2(DEPTH) bits.
- Pointers wrap naturally modulo DEPTH.
- `count` is a separate counter:
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push and pop
- `empty` = (`count` == 0); `full` = (`count` == DEPTH).
- `rd_*` outputs are combinational from storage[rd_ptr] (show-ahead). Their value is don't-care when empty.

Flush:
- Resets the pointers and `count`, and clears `overrun`.
- Has priority over push, pop and `clear_overrun`.
- An entry captured in the same cycle as `flush` is discarded without setting `overrun`.
- The capture FSM is unaffected by flush and still completes the acknowledge.

Overrun flag:
- `overrun` set has priority over `clear_overrun` in the same cycle.

## Timing
- Reset values: `clear_rx_ready`=0, `empty`=1, `full`=0, `count`=0, `overrun`=0, `rx_irq`=0, FSM=CAP_IDLE, pointers=0. Storage contents are not reset.
- Capture latency:
  - `rx_ready` seen high at edge N → entry visible (`empty`=0, `count` incremented) after edge N.
  - `clear_rx_ready` is high during cycle N+1 only.
- Pop: `rd_en` high at edge M → `rd_ptr` and `count` update after M. The next head appears combinationally in the same cycle.
- Back-to-back characters: the minimum capture spacing is 3 cycles, far shorter than any frame. Characters are never lost while the FIFO has space.
- `rx_irq`, `empty`, `full` are derived combinationally from the registered `count`.
- Async reset mid-handshake returns the FSM to CAP_IDLE. If the receiver still holds `rx_ready`, the character is captured after reset release.

## Structure
- Shared package (alongside `uart_config_t` in defines.vh):
  - `uart_rx_entry_t` packed struct: {parity_error, frame_error, data[7:0]}
  - capture-state enum
- Natural sub-module: `sync_fifo`, a generic width/depth show-ahead FIFO with push, pop, flush, count, full and empty.
- `uart_rx_fifo` contains the capture FSM, the overrun logic and the `sync_fifo` instance (WIDTH = $bits(`uart_rx_entry_t`)).

## Test plan
- Single char: receiver model presents 0xA5, no errors → one `clear_rx_ready` pulse one cycle later; `count`=1; `rd_data`=0xA5; `rd_en` → `empty`=1.
- Error flags: 0x3C with `frame_error`=1, then 0x7E with `parity_error`=1 → popped in order with matching `rd_frame_error` / `rd_parity_error`.
- Fill and overrun: 16 chars 0x00..0x0F, then 0xFF with no reads → `full`=1 and `overrun`=1; 0xFF is still acknowledged. Reads return 0x00..0x0F; `clear_overrun` → `overrun`=0.
- Full with simultaneous pop: `full`, `rd_en` high in the same cycle as capture → `count` stays 16, `overrun` stays 0, and the new char is last out.
- Threshold / flush: 8 chars → `rx_irq`=1 exactly when `count` reaches 8; `flush` → `count`=0, `rx_irq`=0, `overrun`=0.
- Async reset: assert `rst_n`=0 during CAP_ACK → all outputs at reset values immediately. If `rx_ready` is still high after release, that char is captured once.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types for the UART receive buffer: the stored entry layout and the capture FSM states.
package uart_rx_fifo_pkg;

  typedef struct packed {
    logic       parity_error;
    logic       frame_error;
    logic [7:0] data;
  } uart_rx_entry_t;

  typedef enum logic [1:0] {
    CAP_IDLE     = 2'd0,
    CAP_ACK      = 2'd1,
    CAP_WAIT_LOW = 2'd2
  } cap_state_t;

  localparam int ENTRY_W = $bits(uart_rx_entry_t);

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and CPU-side signals of the UART receive buffer; slave is the buffer, master drives it.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          frame_error;
  logic          parity_error;
  logic          clear_rx_ready;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_frame_error;
  logic          rd_parity_error;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overrun;
  logic          clear_overrun;
  logic          flush;
  logic          rx_irq;

  modport master (
    output rx_ready, rx_data, frame_error, parity_error, rd_en, clear_overrun, flush,
    input  clear_rx_ready, rd_data, rd_frame_error, rd_parity_error,
    input  empty, full, count, overrun, rx_irq
  );

  modport slave (
    input  rx_ready, rx_data, frame_error, parity_error, rd_en, clear_overrun, flush,
    output clear_rx_ready, rd_data, rd_frame_error, rd_parity_error,
    output empty, full, count, overrun, rx_irq
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic show-ahead FIFO: write visible at rd_dat one cycle after push, pop takes effect at the edge.
// Push is dropped when full unless a pop frees the slot in the same cycle; pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_dat,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset; the count gates what is ever read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures each received character with its error flags into a show-ahead FIFO; entry visible one cycle after rx_ready.
// clear_rx_ready pulses once per character; a character arriving while full (and not popped) is dropped and sets overrun.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_fifo_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  cap_state_t     state;
  cap_state_t     state_nxt;
  logic           capture;
  logic           push_ok;
  logic           clear_rx_ready_q;
  logic           overrun_q;
  uart_rx_entry_t wr_entry;
  uart_rx_entry_t head;
  logic [ENTRY_W-1:0] head_raw;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      CAP_IDLE: begin
        if (bus.rx_ready) begin
          capture   = 1'b1;
          state_nxt = CAP_ACK;
        end
      end
      CAP_ACK:      state_nxt = CAP_WAIT_LOW;
      CAP_WAIT_LOW: if (!bus.rx_ready) state_nxt = CAP_IDLE;
      default:      state_nxt = CAP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= CAP_IDLE;
      clear_rx_ready_q <= 1'b0;
    end else begin
      state            <= state_nxt;
      clear_rx_ready_q <= capture;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO being read does not overrun.
  assign push_ok = !fifo_full || (bus.rd_en && !fifo_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   overrun_q <= 1'b0;
    else if (bus.flush)           overrun_q <= 1'b0;
    else if (capture && !push_ok) overrun_q <= 1'b1;
    else if (bus.clear_overrun)   overrun_q <= 1'b0;
  end

  assign wr_entry.parity_error = bus.parity_error;
  assign wr_entry.frame_error  = bus.frame_error;
  assign wr_entry.data         = bus.rx_data;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (bus.flush),
    .wr_en  (capture),
    .wr_dat (wr_entry),
    .rd_en  (bus.rd_en),
    .rd_dat (head_raw),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign head                = head_raw;
  assign bus.rd_data         = head.data;
  assign bus.rd_frame_error  = head.frame_error;
  assign bus.rd_parity_error = head.parity_error;
  assign bus.clear_rx_ready  = clear_rx_ready_q;
  assign bus.empty           = fifo_empty;
  assign bus.full            = fifo_full;
  assign bus.count           = fifo_count;
  assign bus.overrun         = overrun_q;
  assign bus.rx_irq          = (fifo_count >= CW'(THRESHOLD));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: cycle table for the handshake, directed fill/overrun/threshold/reset sequences,
// then random traffic compared against a queue-based model of the buffer.
module tb_uart_rx_fifo;
  localparam int DEP = 16;
  localparam int THR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEP)) bus ();

  uart_rx_fifo #(.DEPTH(DEP), .THRESHOLD(THR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int rx, d, fe, pe, rd, fl;
    int ex_clr, ex_cnt, ex_head;
  } vec_t;

  vec_t       vt [17];
  int         n_pass = 0;
  int         n_chk = 0;
  logic [9:0] q [$];
  bit         m_ov = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model: one clock edge's worth of buffer effect, evaluated on pre-edge occupancy.
  task automatic model(input bit cap, input logic [9:0] ent, input bit rd, input bit fl, input bit clr);
    bit pop, acc;
    pop = rd && (q.size() != 0);
    acc = (q.size() < DEP) || pop;
    if (fl) begin
      q.delete();
      m_ov = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (cap && acc) q.push_back(ent);
      if (cap && !acc) m_ov = 1'b1;
      else if (clr) m_ov = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("count",   int'(bus.count), q.size());
    chk("empty",   bus.empty,   q.size() == 0);
    chk("full",    bus.full,    q.size() == DEP);
    chk("rx_irq",  bus.rx_irq,  q.size() >= THR);
    chk("overrun", bus.overrun, m_ov);
    if (q.size() != 0)
      chk("head", {bus.rd_parity_error, bus.rd_frame_error, bus.rd_data}, q[0]);
  endtask

  task automatic cyc(input bit rx, input logic [9:0] ent, input bit cap,
                     input bit rd, input bit fl, input bit clr);
    bus.rx_ready      = rx;
    bus.rx_data       = ent[7:0];
    bus.frame_error   = ent[8];
    bus.parity_error  = ent[9];
    bus.rd_en         = rd;
    bus.flush         = fl;
    bus.clear_overrun = clr;
    model(cap, ent, rd, fl, clr);
    @(posedge clk);
    #1;
    check_model();
  endtask

  // One character from the receiver: rx_ready high for one cycle, then low until the FSM is idle again.
  task automatic send(input logic [9:0] ent, input bit rd0, input bit fl0, input bit clr0,
                      input bit rd1, input bit rd2);
    cyc(1'b1, ent, 1'b1, rd0, fl0, clr0);
    chk("ack_pulse", bus.clear_rx_ready, 1);
    cyc(1'b0, ent, 1'b0, rd1, 1'b0, 1'b0);
    chk("ack_low", bus.clear_rx_ready, 0);
    cyc(1'b0, ent, 1'b0, rd2, 1'b0, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_clr"},   bus.clear_rx_ready, 0);
    chk({tag, "_empty"}, bus.empty, 1);
    chk({tag, "_full"},  bus.full, 0);
    chk({tag, "_count"}, int'(bus.count), 0);
    chk({tag, "_ovr"},   bus.overrun, 0);
    chk({tag, "_irq"},   bus.rx_irq, 0);
  endtask

  initial begin
    vt[0]  = '{1, 'hA5, 0, 0, 0, 0, 1, 1, 'h0A5};
    vt[1]  = '{0, 0,    0, 0, 0, 0, 0, 1, 'h0A5};
    vt[2]  = '{0, 0,    0, 0, 1, 0, 0, 0, 0};
    vt[3]  = '{1, 'h3C, 1, 0, 0, 0, 1, 1, 'h13C};
    vt[4]  = '{0, 0,    0, 0, 0, 0, 0, 1, 'h13C};
    vt[5]  = '{0, 0,    0, 0, 0, 0, 0, 1, 'h13C};
    vt[6]  = '{1, 'h7E, 0, 1, 0, 0, 1, 2, 'h13C};
    vt[7]  = '{0, 0,    0, 0, 1, 0, 0, 1, 'h27E};
    vt[8]  = '{0, 0,    0, 0, 1, 0, 0, 0, 0};
    vt[9]  = '{1, 'h55, 0, 0, 0, 0, 1, 1, 'h055};
    vt[10] = '{1, 'h55, 0, 0, 0, 0, 0, 1, 'h055};
    vt[11] = '{1, 'h55, 0, 0, 0, 0, 0, 1, 'h055};
    vt[12] = '{0, 0,    0, 0, 0, 0, 0, 1, 'h055};
    vt[13] = '{0, 0,    0, 0, 0, 1, 0, 0, 0};
    vt[14] = '{1, 'h66, 0, 0, 0, 1, 1, 0, 0};
    vt[15] = '{0, 0,    0, 0, 0, 0, 0, 0, 0};
    vt[16] = '{0, 0,    0, 0, 0, 0, 0, 0, 0};

    bus.rx_ready = 1'b0; bus.rx_data = 8'h00; bus.frame_error = 1'b0; bus.parity_error = 1'b0;
    bus.rd_en = 1'b0; bus.flush = 1'b0; bus.clear_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Cycle table: single char, error flags, held rx_ready, flush with a same-cycle capture.
    for (int i = 0; i < 17; i++) begin
      bus.rx_ready      = 1'(vt[i].rx);
      bus.rx_data       = 8'(vt[i].d);
      bus.frame_error   = 1'(vt[i].fe);
      bus.parity_error  = 1'(vt[i].pe);
      bus.rd_en         = 1'(vt[i].rd);
      bus.flush         = 1'(vt[i].fl);
      bus.clear_overrun = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_clr", i),   bus.clear_rx_ready, vt[i].ex_clr);
      chk($sformatf("vec%0d_count", i), int'(bus.count), vt[i].ex_cnt);
      chk($sformatf("vec%0d_empty", i), bus.empty, vt[i].ex_cnt == 0);
      chk($sformatf("vec%0d_ovr", i),   bus.overrun, 0);
      if (vt[i].ex_cnt != 0)
        chk($sformatf("vec%0d_head", i),
            {bus.rd_parity_error, bus.rd_frame_error, bus.rd_data}, vt[i].ex_head);
    end

    // Fill, overrun on the 17th char, drain in order, then clear the sticky flag.
    for (int i = 0; i < 16; i++) send(10'(i), 0, 0, 0, 0, 0);
    send(10'h0FF, 0, 0, 0, 0, 0);
    chk("fill_full", bus.full, 1);
    chk("fill_ovr", bus.overrun, 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", bus.rd_data, i);
      cyc(0, 0, 0, 1, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    chk("clr_ovr", bus.overrun, 0);

    // Full with a pop in the capture cycle: no overrun, new char last out.
    for (int i = 0; i < 16; i++) send(10'(8'h20 + i), 0, 0, 0, 0, 0);
    send(10'h099, 1, 0, 0, 0, 0);
    chk("fullpop_count", int'(bus.count), 16);
    chk("fullpop_ovr", bus.overrun, 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1, 0, 0);
    chk("fullpop_last", bus.rd_data, 'h99);
    cyc(0, 0, 0, 1, 0, 0);

    // Threshold edge, then overrun and a flush clearing everything.
    for (int i = 0; i < 8; i++) begin
      send(10'(8'h40 + i), 0, 0, 0, 0, 0);
      chk("irq_edge", bus.rx_irq, i == 7);
    end
    for (int i = 0; i < 9; i++) send(10'(8'h50 + i), 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("flush_count", int'(bus.count), 0);
    chk("flush_irq", bus.rx_irq, 0);
    chk("flush_ovr", bus.overrun, 0);

    // Async reset while acknowledging; the still-held character is captured once afterwards.
    cyc(1, 10'h0C3, 1, 0, 0, 0);
    chk("rst_ack", bus.clear_rx_ready, 1);
    #2 rst_n = 1'b0;
    q.delete();
    m_ov = 1'b0;
    #1;
    check_reset_vals("async");
    #2 rst_n = 1'b1;
    cyc(1, 10'h0C3, 1, 0, 0, 0);
    chk("rst_recap", bus.clear_rx_ready, 1);
    cyc(1, 10'h0C3, 0, 0, 0, 0);
    cyc(1, 10'h0C3, 0, 0, 0, 0);
    cyc(0, 10'h0C3, 0, 0, 0, 0);
    cyc(0, 10'h0C3, 0, 0, 0, 0);
    chk("rst_once", int'(bus.count), 1);
    cyc(0, 0, 0, 1, 0, 0);

    // Random traffic: biased toward filling so overrun, full-with-pop and flush all occur.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0)
        send(10'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      else
        cyc(0, 0, 0, $urandom_range(0, 1) == 1, 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
